// File: rtl/bus_demux1to4.sv
// bus_demux1to4: steers one initiator request to one of four targets
// by address decode and returns the selected target's response.
//
// Ports:
//   clk, rst        clock (rising edge), async active-high reset
//   req_valid/ready initiator request handshake (ready only in IDLE)
//   req_addr/we/wdata/be  initiator request fields
//   rsp_valid       one-cycle response pulse
//   rsp_rdata       read data (0 on writes and errors)
//   rsp_err         error qualifier (bad address or timeout)
//   t_req_valid[4]  one-hot request valid per target
//   t_req_ready[4]  per-target request ready
//   t_addr/we/wdata/be  latched request, shared by all targets
//   t_rsp_valid[4]  per-target response valid
//   t_rsp_rdata     packed read data, target n at [32n+31:32n]
module bus_demux1to4 #(
  parameter int unsigned SEL_LSB = 28,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [31:0]  req_addr,
  input  logic         req_we,
  input  logic [31:0]  req_wdata,
  input  logic [3:0]   req_be,
  output logic         rsp_valid,
  output logic [31:0]  rsp_rdata,
  output logic         rsp_err,
  output logic [3:0]   t_req_valid,
  input  logic [3:0]   t_req_ready,
  output logic [31:0]  t_addr,
  output logic         t_we,
  output logic [31:0]  t_wdata,
  output logic [3:0]   t_be,
  input  logic [3:0]   t_rsp_valid,
  input  logic [127:0] t_rsp_rdata
);

  localparam logic [15:0] TMO = TIMEOUT[15:0];

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    RSP  = 3'd3,
    ERR  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;

  logic        accept;
  logic        legal;
  logic [1:0]  req_sel;
  logic        tgt_rdy;
  logic        tgt_rsp;
  logic [31:0] tgt_rdata;
  logic [15:0] cnt_inc;
  logic        tmo;

  // Address decode on the live request.
  // Shifting past the word yields 0, so
  // a select field at the top bits is legal.
  assign legal   = (req_addr >> (SEL_LSB + 2)) == 32'd0;
  assign req_sel = req_addr[SEL_LSB+1:SEL_LSB];
  assign accept  = (state_q == IDLE) && req_valid;

  // Selected-target view of the return path.
  always_comb begin
    tgt_rdy   = 1'b0;
    tgt_rsp   = 1'b0;
    tgt_rdata = 32'd0;
    unique case (sel_q)
      2'd0: begin
        tgt_rdy   = t_req_ready[0];
        tgt_rsp   = t_rsp_valid[0];
        tgt_rdata = t_rsp_rdata[31:0];
      end
      2'd1: begin
        tgt_rdy   = t_req_ready[1];
        tgt_rsp   = t_rsp_valid[1];
        tgt_rdata = t_rsp_rdata[63:32];
      end
      2'd2: begin
        tgt_rdy   = t_req_ready[2];
        tgt_rsp   = t_rsp_valid[2];
        tgt_rdata = t_rsp_rdata[95:64];
      end
      2'd3: begin
        tgt_rdy   = t_req_ready[3];
        tgt_rsp   = t_rsp_valid[3];
        tgt_rdata = t_rsp_rdata[127:96];
      end
      default: ;
    endcase
  end

  // Timeout fires on the cycle the count
  // would reach TIMEOUT, so REQ+WAIT lasts
  // exactly TIMEOUT cycles.
  assign cnt_inc = cnt_q + 16'd1;
  assign tmo     = (cnt_inc == TMO);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A response on the
  // timeout cycle takes priority.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = legal ? REQ : ERR;
        end
      end
      REQ: begin
        if (tgt_rdy && tgt_rsp) begin
          state_d = RSP;
        end else if (tmo) begin
          state_d = ERR;
        end else if (tgt_rdy) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (tgt_rsp) begin
          state_d = RSP;
        end else if (tmo) begin
          state_d = ERR;
        end
      end
      RSP:     state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values.
  always_comb begin
    sel_d   = sel_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    if (accept) begin
      sel_d   = req_sel;
      addr_d  = req_addr;
      we_d    = req_we;
      wdata_d = req_wdata;
      be_d    = req_be;
      cnt_d   = 16'd0;
      rdata_d = 32'd0;
    end else if (state_q == REQ ||
                 state_q == WAIT) begin
      cnt_d = cnt_inc;
      if (state_d == RSP) begin
        rdata_d = we_q ? 32'd0 : tgt_rdata;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q   <= 2'd0;
      addr_q  <= 32'd0;
      we_q    <= 1'b0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      cnt_q   <= 16'd0;
      rdata_q <= 32'd0;
    end else begin
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs. req_ready is held low while
  // rst is asserted.
  always_comb begin
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    rsp_err     = 1'b0;
    rsp_rdata   = 32'd0;
    t_req_valid = 4'd0;
    unique case (state_q)
      IDLE: req_ready = ~rst;
      REQ:  t_req_valid = 4'b0001 << sel_q;
      WAIT: ;
      RSP: begin
        rsp_valid = 1'b1;
        rsp_rdata = rdata_q;
      end
      ERR: begin
        rsp_valid = 1'b1;
        rsp_err   = 1'b1;
      end
      default: ;
    endcase
  end

  assign t_addr  = addr_q;
  assign t_we    = we_q;
  assign t_wdata = wdata_q;
  assign t_be    = be_q;

endmodule

// File: doc/bus_demux1to4.md
Name: bus_demux1to4

Overview:
- Initiator-side steering block: routes one initiator request (from the CPU data port) to one of four target ports by address decode.
- Returns the selected target's response to the initiator; non-selected targets' responses are ignored.
- Complements the 4:1 read-data mux: handles the request direction plus transaction tracking.
- One transaction outstanding at a time; undecodable addresses and hung targets produce an error response.

Parameters:
- SEL_LSB, 28: low bit of the 2-bit target select field. sel = req_addr[SEL_LSB+1:SEL_LSB].
- TIMEOUT, 255: cycles allowed in REQ+WAIT before the block aborts with an error. Range 1..65535.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- req_valid  in  1  initiator request valid
- req_ready  out  1  block can accept a request (IDLE only)
- req_addr  in  32  request address
- req_we  in  1  1 = write, 0 = read
- req_wdata  in  32  write data
- req_be  in  4  byte enables
- rsp_valid  out  1  one-cycle response pulse; initiator always accepts
- rsp_rdata  out  32  read data (0 on writes and on errors)
- rsp_err  out  1  error qualifier, valid with rsp_valid
- t_req_valid  out  4  one-hot request valid per target
- t_req_ready  in  4  per-target request ready
- t_addr  out  32  latched address, shared by all targets
- t_we  out  1  latched write enable, shared
- t_wdata  out  32  latched write data, shared
- t_be  out  4  latched byte enables, shared
- t_rsp_valid  in  4  per-target response valid
- t_rsp_rdata  in  128  packed read data; target n at [32n+31:32n]

Behaviour:
- Reset (async, active-high) forces:
  - state = IDLE; all registers = 0.
  - rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, t_req_valid = 0.
  - req_ready = 1 once rst is deasserted.
- Reset mid-transaction: aborts the transaction immediately, no response is issued, and targets see t_req_valid drop asynchronously.
- Address decode:
  - A request is legal iff req_addr[31:SEL_LSB+2] == 0.
  - sel is latched at accept.
- IDLE:
  - req_ready = 1.
  - On req_valid (accept at cycle 0): latch addr/we/wdata/be into the t_* outputs and latch sel.
  - Legal address: go to REQ. Illegal address: go to ERR.
- REQ:
  - t_req_valid[sel] = 1; all other bits 0. Timeout counter increments every cycle.
  - On t_req_ready[sel] with t_rsp_valid[sel] in the same cycle: go to RSP.
  - On t_req_ready[sel] alone: go to WAIT.
- WAIT:
  - t_req_valid = 0; counter keeps incrementing.
  - On t_rsp_valid[sel]: go to RSP.
- Response capture (on entry to RSP):
  - rsp_rdata = t_rsp_rdata slice[sel] for reads, 0 for writes; rsp_err = 0.
- RSP:
  - rsp_valid = 1 for exactly one cycle; return to IDLE the next cycle.
  - req_ready = 0 during RSP, so there is no back-to-back accept.
- ERR:
  - rsp_valid = 1, rsp_err = 1, rsp_rdata = 0 for one cycle; then IDLE.
  - Illegal-address latency: accept at cycle 0, error response at cycle 1.
- Timeout:
  - When the counter reaches TIMEOUT in REQ or WAIT, go to ERR and drop t_req_valid.
  - Counter is cleared on every accept.
  - A t_rsp_valid arriving on the same cycle as the timeout wins: the transaction completes normally.
- Latency, zero-wait target: accept at cycle 0, t_req_valid at cycle 1, rsp_valid at cycle 2.
- Responses from non-selected targets, or arriving in IDLE/RSP/ERR, are ignored with no state change.
- req_* inputs are ignored outside IDLE.
- t_* shared outputs hold their latched values until the next accept.

Test Plan:
- Read, zero-wait target 2: req_addr=0x2000_0010, target 2 ready and responds 0xDEADBEEF in the same cycle -> t_req_valid=4'b0100 at cycle 1; rsp_valid=1, rsp_rdata=0xDEADBEEF, rsp_err=0 at cycle 2.
- Write with waits to target 1: addr 0x1000_0004, wdata 0x12345678, be 4'b0011, ready after 3 cycles, response 2 cycles later -> t_req_valid=4'b0010 held 3 cycles; t_wdata/t_be stable; rsp_valid pulse with rsp_rdata=0.
- Illegal address 0x4000_0000 -> no t_req_valid; rsp_valid=1, rsp_err=1 at cycle 1; req_ready=1 at cycle 2.
- Timeout: TIMEOUT=8, target 3 never ready -> t_req_valid[3] drops and rsp_err=1 pulses 9 cycles after accept.
- Spurious responses: t_rsp_valid[0] asserted while sel=1 is in WAIT -> ignored; completion only on t_rsp_valid[1], carrying target 1's data.
- Reset in WAIT: rst=1 -> t_req_valid=0 and rsp_valid=0 immediately; after release, req_ready=1 and a new read completes normally.
